// File: rtl/scc_pkg.sv
// Shared types for the core's memory-port arbiter.
// Holds the FSM state encoding, requester IDs and the default timeout budget.
package scc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } arb_state_t;

   // Requester IDs, shared with the fetch and execute stages.
   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   localparam int DEFAULT_TIMEOUT = 16;

   // Width of a counter that holds 0..t, with a minimum of one bit.
   function automatic int ctr_width(input int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle budget counter for a granted memory transaction.
// expire is raised while the count sits at TIMEOUT-1; TIMEOUT = 0 never expires.
module arb_timeout_ctr
   import scc_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = ctr_width(TIMEOUT);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expire = 1'b0;
      end else begin : g_on
         logic [CW-1:0] count;

         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         always_ff @(posedge clk) begin
            if (reset || clear)
               count <= '0;
            else if (enable)
               count <= count + CW'(1);
         end

         assign expire = (count == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data has fixed priority.
module mem_port_arbiter
   import scc_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          bus_err
);

   arb_state_t state;
   logic       busy;
   logic       expire;
   logic       done;
   logic       grant_d;
   logic       grant_if;

   assign busy = (state != IDLE);
   // Completion is suppressed during reset so a transaction cut short gets no ack.
   assign done = busy && !reset && (mem_ack || expire);

`ifdef ARB_ROUND_ROBIN_EN
   req_id_t last_grant;

   assign grant_d = d_req && (!if_req || (last_grant == REQ_IF));

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= REQ_IF;
      else if (state == IDLE && grant_d)
         last_grant <= REQ_D;
      else if (state == IDLE && grant_if)
         last_grant <= REQ_IF;
   end
`else
   assign grant_d = d_req;
`endif

   assign grant_if = if_req && !grant_d;

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (!busy),
      .enable (busy && !mem_ack),
      .expire (expire)
   );

   // A timeout abort returns zero data; a store always returns zero data.
   always_comb begin
      if_ack   = (state == IF_BUSY) && done;
      d_ack    = (state == D_BUSY) && done;
      bus_err  = done && !mem_ack;
      if_rdata = (if_ack && mem_ack) ? mem_rdata : '0;
      d_rdata  = (d_ack && mem_ack && mem_rd) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= D_BUSY;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_wr    <= d_we;
                  mem_rd    <= !d_we;
               end else if (grant_if) begin
                  state    <= IF_BUSY;
                  mem_addr <= if_addr;
                  mem_rd   <= 1'b1;
               end
            end
            IF_BUSY, D_BUSY: begin
               if (done) begin
                  state  <= IDLE;
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (TIMEOUT = 4).
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it defined.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW      (32),
      .DW      (32),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err)
   );

   // flags = {if_ack, d_ack, mem_rd, mem_wr, bus_err}
   typedef struct {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic [4:0]  flags;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] if_rdata;
      logic [31:0] d_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic ma, input logic [31:0] mrd,
                      input logic [4:0] fl, input logic [31:0] maddr,
                      input logic [31:0] mwd, input logic [31:0] ird,
                      input logic [31:0] drd);
      vec_t v;
      v.rst = rst;  v.if_req = ir;  v.if_addr = ia;
      v.d_req = dr; v.d_we = dwe;   v.d_addr = da;  v.d_wdata = dwd;
      v.mem_ack = ma; v.mem_rdata = mrd;
      v.flags = fl; v.mem_addr = maddr; v.mem_wdata = mwd;
      v.if_rdata = ird; v.d_rdata = drd;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset     = v.rst;
      if_req    = v.if_req;
      if_addr   = v.if_addr;
      d_req     = v.d_req;
      d_we      = v.d_we;
      d_addr    = v.d_addr;
      d_wdata   = v.d_wdata;
      mem_ack   = v.mem_ack;
      mem_rdata = v.mem_rdata;
   endtask

   initial begin
      logic [4:0]  r10_flags;
      logic [31:0] r10_addr;
      logic [31:0] r10_ird;
      logic [31:0] r10_drd;
      bit          rr;

`ifdef ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      // Second tie follows a data grant: round robin serves fetch, fixed priority data.
      r10_flags = rr ? 5'b10100 : 5'b01100;
      r10_addr  = rr ? 32'h104 : 32'h204;
      r10_ird   = rr ? 32'h2222 : 32'h0;
      r10_drd   = rr ? 32'h0 : 32'h2222;

      //   rst ifr ifaddr   dr we daddr    dwdata   ack rdata          flags     maddr    mwdata   if_rd          d_rd
      add(1, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h0,   32'h0,  32'h0,        32'h0);     // r0 reset state
      add(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h0,   32'h0,  32'h0,        32'h0);     // r1 fetch seen
      add(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00100, 32'h100, 32'h0,  32'h0,        32'h0);
      add(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00100, 32'h100, 32'h0,  32'h0,        32'h0);
      add(0, 1, 32'h100, 0, 0, 32'h0,   32'h0,  1, 32'hDEADBEEF, 5'b10100, 32'h100, 32'h0,  32'hDEADBEEF, 32'h0);     // r4 fetch ack
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h100, 32'h0,  32'h0,        32'h0);
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  1, 32'h77,       5'b00000, 32'h100, 32'h0,  32'h0,        32'h0);     // r6 ack in IDLE ignored
      add(0, 1, 32'h104, 1, 1, 32'h200, 32'h55, 0, 32'h0,        5'b00000, 32'h100, 32'h0,  32'h0,        32'h0);     // r7 tie
      add(0, 1, 32'h104, 1, 1, 32'h200, 32'h55, 1, 32'hAAAA,     5'b01010, 32'h200, 32'h55, 32'h0,        32'h0);     // r8 store wins
      add(0, 1, 32'h104, 1, 0, 32'h204, 32'h55, 0, 32'h0,        5'b00000, 32'h200, 32'h55, 32'h0,        32'h0);     // r9 second tie
      add(0, 1, 32'h104, 1, 0, 32'h204, 32'h55, 1, 32'h2222,     r10_flags, r10_addr, 32'h55, r10_ird,     r10_drd);
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, r10_addr, 32'h55, 32'h0,       32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00000, r10_addr, 32'h55, 32'h0,       32'h0);     // r12 load, no ack
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h5A5A,     5'b01101, 32'h300, 32'h66, 32'h0,        32'h0);     // r16 timeout abort
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h300, 32'h66, 32'h0,        32'h0);     // r17 mem_rd dropped
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00000, 32'h300, 32'h66, 32'h0,        32'h0);     // r18 load again
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 0, 32'h0,        5'b00100, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 0, 32'h0,   1, 0, 32'h300, 32'h66, 1, 32'h1234,     5'b01100, 32'h300, 32'h66, 32'h0,        32'h1234);  // r22 ack at expiry
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h300, 32'h66, 32'h0,        32'h0);
      add(0, 1, 32'h400, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h300, 32'h66, 32'h0,        32'h0);     // r24 fetch seen
      add(0, 1, 32'h400, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00100, 32'h400, 32'h66, 32'h0,        32'h0);
      add(1, 1, 32'h400, 0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00100, 32'h400, 32'h66, 32'h0,        32'h0);     // r26 reset mid-flight
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  1, 32'h9999,     5'b00000, 32'h0,   32'h0,  32'h0,        32'h0);     // r27 late ack ignored
      add(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,  0, 32'h0,        5'b00000, 32'h0,   32'h0,  32'h0,        32'h0);

      reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("r%0d flags", i), 64'({if_ack, d_ack, mem_rd, mem_wr, bus_err}), 64'(vecs[i].flags));
         check($sformatf("r%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].mem_addr));
         check($sformatf("r%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].mem_wdata));
         check($sformatf("r%0d if_rdata", i), 64'(if_rdata), 64'(vecs[i].if_rdata));
         check($sformatf("r%0d d_rdata", i), 64'(d_rdata), 64'(vecs[i].d_rdata));
         @(negedge clk);
      end

      // Zero-wait streaming with both requesters held: grant every second cycle.
      if_req = 1'b1; if_addr = 32'h600;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_wdata = 32'h0;
      for (int i = 0; i < 8; i++) begin
         logic       exp_d;
         logic [1:0] exp_ack;
         mem_ack   = mem_rd | mem_wr;
         mem_rdata = 32'hC000 + 32'(i);
         #1;
         exp_d   = rr ? ((i / 2) % 2 == 0) : 1'b1;
         exp_ack = (i % 2 == 1) ? {!exp_d, exp_d} : 2'b00;
         check($sformatf("stream%0d acks", i), 64'({if_ack, d_ack}), 64'(exp_ack));
         if (i % 2 == 1)
            check($sformatf("stream%0d mem_addr", i), 64'(mem_addr),
                  exp_d ? 64'h500 : 64'h600);
         else
            check($sformatf("stream%0d strobes", i), 64'({mem_rd, mem_wr}), 64'h0);
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch stage and the load/store path of the execute stage. Sits between the fetch/execute logic and external memory, replacing the separate instruction and data ports with one arbitrated, variable-latency port. Sequences one transaction at a time through a three-state FSM. Provides per-requester acknowledge and read data, and aborts transactions that exceed a cycle budget.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles a granted transaction waits for mem_ack; 0 disables timeout

Ports:
- clk  in  1  main clock
- reset  in  1  synchronous, active-high; one clock domain
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  fetch complete (one-cycle pulse)
- if_rdata  out  DW  fetched instruction, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  data complete (one-cycle pulse)
- d_rdata  out  DW  load data, valid with d_ack
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_rd  out  1  memory read strobe, level, held until mem_ack
- mem_wr  out  1  memory write strobe, level, held until mem_ack
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- bus_err  out  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - If d_req is asserted, go to D_BUSY. Latch d_addr, d_wdata, d_we. Next cycle mem_wr = d_we and mem_rd = !d_we.
  - Else if if_req, go to IF_BUSY. Latch if_addr. Next cycle mem_rd = 1.
  - Requests are not acknowledged in IDLE.
- BUSY states:
  - When mem_ack = 1, pulse the matching requester ack combinationally in the same cycle.
  - Pass mem_rdata through to if_rdata/d_rdata. Stores return d_rdata = 0.
  - Go to IDLE. mem_rd/mem_wr drop on the next edge.
- mem_ack is ignored in IDLE, and the non-matching ack never fires.
- Timeout: a counter clears on grant and increments each BUSY cycle without mem_ack. If it reaches TIMEOUT-1 with no ack:
  - pulse the requester ack with rdata = 0;
  - pulse bus_err;
  - return to IDLE.
  - If mem_ack and expiry fall in the same cycle, mem_ack wins and bus_err stays 0.
- A requester still holding req in the cycle after its ack is treated as a new request.
- Reset values:
  - state IDLE;
  - mem_addr, mem_wdata = 0;
  - mem_rd, mem_wr = 0;
  - if_ack, d_ack, bus_err = 0;
  - rdata outputs = 0;
  - counter = 0.
- Reset mid-transaction:
  - return to IDLE at the reset edge and drop the strobes;
  - the in-flight request gets no ack;
  - a late mem_ack is ignored.

## Timing
- Request seen in cycle N → strobes asserted in N+1 → earliest ack in N+1, with zero-wait memory.
- Back-to-back transactions take at least 2 cycles each. IDLE is mandatory between transactions.
- mem_addr, mem_wdata and the strobes are stable from grant until the cycle after mem_ack.
- Timeout abort occurs in cycle N+TIMEOUT after grant.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: when both requests are pending in IDLE, grant the requester not served last. A one-bit last-grant register resets to "fetch", so data wins the first tie.
  - Undefined: fixed priority, data always beats fetch, and the last-grant register is not built.

## Structure
- The package scc_pkg holds:
  - the arb_state_t enum (IDLE, IF_BUSY, D_BUSY);
  - the default TIMEOUT;
  - the requester-ID encoding shared with fetch/execute.
- One sub-module, arb_timeout_ctr: clear, enable, expire output, sized clog2(TIMEOUT+1), constant-0 expire when TIMEOUT = 0.

## Test plan
- Single fetch: if_req = 1 with if_addr = 0x100, memory acks 2 cycles after mem_rd with 0xDEADBEEF → mem_addr = 0x100 from cycle 1, if_ack in cycle 3, if_rdata = 0xDEADBEEF, d_ack never asserted.
- Simultaneous requests: if_req and d_req with d_we = 1, d_addr = 0x200, d_wdata = 0x55 in the same cycle.
  - Fixed priority: store first (mem_wr = 1, mem_wdata = 0x55), then fetch after IDLE.
  - With ARB_ROUND_ROBIN_EN: a second tie grants fetch.
- Zero-wait streaming: both requests held continuously, mem_ack tied to the strobes.
  - Fixed priority: a grant every 2 cycles, all to data.
  - Round robin: grants alternate data, fetch, data, fetch.
- Timeout: TIMEOUT = 4, load to 0x300, memory never acks → d_ack = 1, d_rdata = 0 and bus_err = 1 in cycle 5, mem_rd low in cycle 6.
- Ack at the expiry cycle: TIMEOUT = 4, mem_ack = 1 with 0x1234 in cycle 5 → d_rdata = 0x1234, bus_err = 0.
- Reset mid-transaction: reset in the second BUSY cycle, mem_ack the cycle after → all outputs 0, state IDLE, no requester ack.
